dat_mem_mover: RTL and testbench
================================

Name: dat_mem_mover

Overview:
- Memory-side initiator that drives the single-port byte data memory: combinational read, write on posedge `clk` when `wr_en` = 1.
- Performs block copy (read src, write dst) or block fill (write constant) over a byte range, with a start/busy/done handshake.
- Sits beside the core; the top level muxes its memory port with the core's load/store port using `busy`.

Parameters:
- AW, 8, address width; memory depth 2^AW bytes.
- DW, 8, data width in bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle request pulse; ignored while busy
- mode  in  1  0 = copy, 1 = fill; sampled with start
- src_addr  in  AW  copy source base; sampled with start
- dst_addr  in  AW  destination base; sampled with start
- length  in  AW+1  byte count, 0..2^AW; sampled with start
- fill_val  in  DW  fill byte; sampled with start
- mem_rd_data  in  DW  memory dat_out (combinational read of mem_addr)
- mem_addr  out  AW  memory address pointer
- mem_wr_data  out  DW  memory dat_in
- mem_wr_en  out  1  memory write enable
- busy  out  1  transfer in progress; top grants memory port to mover
- done  out  1  one-cycle pulse on completion
- bytes_left  out  AW+1  remaining byte count

Behaviour:
- Reset (sync, active-high, wins over everything):
  - state = IDLE; mem_addr = 0, mem_wr_data = 0, mem_wr_en = 0, busy = 0, done = 0, bytes_left = 0.
- States and transitions:
  - IDLE:
    - start = 1 → latch src/dst/length/mode/fill_val.
    - length = 0 → DONE.
    - Otherwise copy → RD; fill → WR.
  - RD (copy only):
    - mem_addr = src pointer, mem_wr_en = 0.
    - Capture mem_rd_data into hold register at clock edge; src++ → WR.
  - WR:
    - mem_addr = dst pointer, mem_wr_data = hold (copy) or fill_val (fill), mem_wr_en = 1.
    - At edge: dst++, bytes_left--.
    - bytes_left reaches 0 → DONE; else copy → RD, fill stays WR.
  - DONE: done = 1 for exactly one cycle, busy = 0 → IDLE.
- busy = 1 in RD and WR only; 0 in IDLE and DONE.
- Outputs are combinational decodes of state + registered pointers; mem_wr_en is never asserted outside WR.
- Latency, start accepted at edge E0:
  - Copy of N ≥ 1 bytes: 2N cycles of busy, done in cycle 2N+1.
  - Fill of N: N busy cycles, done in cycle N+1.
  - length 0: done in cycle 1, no writes.
- Address arithmetic:
  - Pointers are AW bits and wrap modulo 2^AW (0xFF + 1 = 0x00).
  - length = 2^AW touches every location exactly once.
- Overlap: copy is strictly forward byte-by-byte. dst in (src, src+N) replicates the leading bytes; this is defined behaviour, no memmove.
- start while busy or in DONE: ignored, no latching, no effect on the current transfer.
- start and reset in the same cycle: reset wins.
- Reset mid-transfer:
  - Abort to IDLE at that edge.
  - Bytes already written remain; no partial write afterward.
  - No done pulse.
- bytes_left loads `length` on accept, decrements on each WR edge, and holds 0 after completion.

Decomposition:
- Shared package dat_mem_pkg:
  - typedef addr_t (logic[AW-1:0]), data_t (logic[DW-1:0]).
  - enum mover_state_t {IDLE, RD, WR, DONE}.
  - constants MODE_COPY = 0, MODE_FILL = 1.
- Sub-module: none required.
- The bench instantiates dat_mem_mover driving a dat_mem instance (mem_addr→addr, mem_wr_data→dat_in, mem_wr_en→wr_en, dat_out→mem_rd_data).

Test Plan:
- Preload mem[60] = 0x10, mem[61] = 0xE0; copy src = 60, dst = 100, len = 2 → mem[100] = 0x10, mem[101] = 0xE0; busy for 4 cycles, done in cycle 5; mem_wr_en high in cycles 2 and 4 only.
- Fill dst = 0xFE, len = 4, fill_val = 0xA5 → mem[0xFE], mem[0xFF], mem[0x00], mem[0x01] = 0xA5; mem[0x02] unchanged; done in cycle 5.
- Copy len = 0 → done in cycle 1, busy never high, mem_wr_en never high, memory unchanged.
- Overlap: mem[10..13] = 1,2,3,4; copy src = 10, dst = 11, len = 3 → mem[11..13] = 1,1,1.
- Second start pulse during a copy of len = 8 (different dst) → ignored; only the first transfer's writes occur; a single done pulse.
- Reset asserted in cycle 3 of a fill len = 6, dst = 20, val = 0x3C → mem[20..22] = 0x3C, mem[23..25] unchanged; no done pulse; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/dat_mem_pkg.sv
// Shared types and constants for the data-memory block mover.
package dat_mem_pkg;
  localparam int AW = 8;
  localparam int DW = 8;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} mover_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/dat_mem.sv
// Single-port byte memory: combinational read, write on rising clock edge.
module dat_mem #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dat_in,
  input  logic          wr_en,
  output logic [DW-1:0] dat_out
);
  logic [DW-1:0] mem_q [2**AW];

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= dat_in;
  end

  assign dat_out = mem_q[addr];
endmodule

// File: rtl/dat_mem_mover.sv
// Block copy / fill engine that owns the data-memory port while busy.
// Copy alternates RD (latch source byte) and WR (store it); fill stays in WR.
module dat_mem_mover #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   length,
  input  logic [DW-1:0] fill_val,
  input  logic [DW-1:0] mem_rd_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          mem_wr_en,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   bytes_left
);
  import dat_mem_pkg::*;

  localparam logic [AW-1:0] ONE_A = 1;
  localparam logic [AW:0]   ONE_C = 1;

  mover_state_t  state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] fill_q, fill_d, hold_q, hold_d;

  // Next-state, pointer updates and output decode
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    fill_d      = fill_q;
    hold_d      = hold_q;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = length;
          mode_d = mode;
          fill_d = fill_val;
          if (length == '0)           state_d = DONE;
          else if (mode == MODE_FILL) state_d = WR;
          else                        state_d = RD;
        end
      end
      RD: begin
        busy     = 1'b1;
        mem_addr = src_q;
        hold_d   = mem_rd_data;
        src_d    = src_q + ONE_A;
        state_d  = WR;
      end
      WR: begin
        busy        = 1'b1;
        mem_addr    = dst_q;
        mem_wr_data = (mode_q == MODE_FILL) ? fill_q : hold_q;
        mem_wr_en   = 1'b1;
        dst_d       = dst_q + ONE_A;
        cnt_d       = cnt_q - ONE_C;
        // Last byte: the count reaches zero at this edge
        if (cnt_q == ONE_C)           state_d = DONE;
        else if (mode_q == MODE_COPY) state_d = RD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pointer registers; reset aborts any transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
    end
  end

  assign bytes_left = cnt_q;
endmodule

// File: tb/tb_dat_mem_mover.sv
// Directed bench for dat_mem_mover driving a dat_mem instance.
module tb_dat_mem_mover;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic [AW-1:0] src_addr, dst_addr, mem_addr;
  logic [AW:0]   length, bytes_left;
  logic [DW-1:0] fill_val, mem_rd_data, mem_wr_data;
  logic          mem_wr_en, busy, done;

  logic [AW-1:0] tb_addr, m_addr;
  logic [DW-1:0] tb_din, m_din;
  logic          tb_we, m_we;

  int n_vec = 0, n_bad = 0;

  // results of the last run
  int          r_done_cyc, r_ndone, r_nbusy, r_nwr, r_wr_nobusy;
  logic [15:0] r_mask;
  logic [AW:0] r_bl1, r_bl_end;
  logic        r_postrst;

  always #5 clk = ~clk;

  assign m_addr = busy ? mem_addr    : tb_addr;
  assign m_din  = busy ? mem_wr_data : tb_din;
  assign m_we   = busy ? mem_wr_en   : tb_we;

  dat_mem_mover #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_val(fill_val), .mem_rd_data(mem_rd_data), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .busy(busy),
    .done(done), .bytes_left(bytes_left)
  );

  dat_mem #(.AW(AW), .DW(DW)) u_mem (
    .clk(clk), .addr(m_addr), .dat_in(m_din), .wr_en(m_we), .dat_out(mem_rd_data)
  );

  typedef struct {
    logic        md;
    logic [7:0]  s, d;
    logic [8:0]  len;
    logic [7:0]  fv;
    int          done_cyc, nbusy, nwr;
    logic [15:0] mask;
    logic [7:0]  a0, v0, a1, v1;
  } vec_t;

  vec_t tbl [5];

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mwr(input logic [7:0] a, input logic [7:0] d);
    tb_addr = a; tb_din = d; tb_we = 1'b1;
    step;
    tb_we = 1'b0;
  endtask

  task automatic mrd(input logic [7:0] a, output logic [7:0] d);
    tb_addr = a;
    #1;
    d = mem_rd_data;
  endtask

  // Launch one transfer and watch it cycle by cycle (cycle 1 = first after accept).
  task automatic run(input logic md, input logic [7:0] s, input logic [7:0] d,
                     input logic [8:0] len, input logic [7:0] fv,
                     input int inj_cyc, input int rst_cyc, input int limit);
    r_done_cyc = 0; r_ndone = 0; r_nbusy = 0; r_nwr = 0; r_wr_nobusy = 0;
    r_mask = '0; r_bl1 = '1; r_bl_end = '1; r_postrst = 1'b0;
    mode = md; src_addr = s; dst_addr = d; length = len; fill_val = fv;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (rst_cyc != 0 && c == rst_cyc + 1)
        r_postrst = (mem_addr == '0) && (mem_wr_data == '0) && !mem_wr_en &&
                    !busy && !done && (bytes_left == '0);
      if (c == 1) r_bl1 = bytes_left;
      if (busy) r_nbusy++;
      if (mem_wr_en) begin
        r_nwr++;
        if (!busy) r_wr_nobusy++;
        if (c < 16) r_mask[c] = 1'b1;
      end
      if (done) begin
        r_ndone++;
        if (r_done_cyc == 0) r_done_cyc = c;
        r_bl_end = bytes_left;
      end
      if (c == inj_cyc) begin
        start = 1'b1; mode = ~md; src_addr = s + 8'h10; dst_addr = d + 8'h40;
        length = 9'd2; fill_val = 8'hEE;
      end
      if (c == rst_cyc) reset = 1'b1;
      if (r_done_cyc != 0 && c >= r_done_cyc + 2) break;
      step;
      start = 1'b0;
      reset = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rd;
    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_val = '0; tb_addr = '0; tb_din = '0; tb_we = 1'b0;

    tbl[0] = '{1'b0, 8'd60, 8'd100, 9'd2,     8'h00, 5,   4,   2,   16'h0014, 8'd100, 8'h10, 8'd101, 8'hE0};
    tbl[1] = '{1'b1, 8'h00, 8'hFE,  9'd4,     8'hA5, 5,   4,   4,   16'h001E, 8'h00,  8'hA5, 8'h02,  8'h77};
    tbl[2] = '{1'b0, 8'd60, 8'd100, 9'd0,     8'h00, 1,   0,   0,   16'h0000, 8'd60,  8'h10, 8'd100, 8'h10};
    tbl[3] = '{1'b0, 8'd10, 8'd11,  9'd3,     8'h00, 7,   6,   3,   16'h0054, 8'd12,  8'h01, 8'd13,  8'h01};
    tbl[4] = '{1'b1, 8'h00, 8'h30,  9'h100,   8'h5A, 257, 256, 256, 16'hFFFE, 8'h2F,  8'h5A, 8'h02,  8'h5A};

    step; step;
    chk("rst_mem_addr",    32'(mem_addr),    0);
    chk("rst_mem_wr_data", 32'(mem_wr_data), 0);
    chk("rst_mem_wr_en",   32'(mem_wr_en),   0);
    chk("rst_busy",        32'(busy),        0);
    chk("rst_done",        32'(done),        0);
    chk("rst_bytes_left",  32'(bytes_left),  0);

    // start together with reset must not launch anything
    start = 1'b1; mode = 1'b1; dst_addr = 8'h05; length = 9'd3;
    step;
    start = 1'b0; reset = 1'b0;
    chk("start_with_reset_busy", 32'(busy), 0);

    for (int i = 0; i < 256; i++) mwr(8'(i), 8'h00);
    mwr(8'd60, 8'h10); mwr(8'd61, 8'hE0); mwr(8'h02, 8'h77);
    for (int i = 0; i < 4; i++) mwr(8'(10 + i), 8'(i + 1));

    for (int v = 0; v < 5; v++) begin
      run(tbl[v].md, tbl[v].s, tbl[v].d, tbl[v].len, tbl[v].fv, 0, 0, 300);
      chk($sformatf("v%0d_done_cycle", v), 32'(r_done_cyc), 32'(tbl[v].done_cyc));
      chk($sformatf("v%0d_done_pulses", v), 32'(r_ndone), 1);
      chk($sformatf("v%0d_busy_cycles", v), 32'(r_nbusy), 32'(tbl[v].nbusy));
      chk($sformatf("v%0d_writes", v), 32'(r_nwr), 32'(tbl[v].nwr));
      chk($sformatf("v%0d_wr_en_mask", v), 32'(r_mask), 32'(tbl[v].mask));
      chk($sformatf("v%0d_wr_outside_busy", v), 32'(r_wr_nobusy), 0);
      chk($sformatf("v%0d_bytes_left_c1", v), 32'(r_bl1), 32'(tbl[v].len));
      chk($sformatf("v%0d_bytes_left_end", v), 32'(r_bl_end), 0);
      mrd(tbl[v].a0, rd);
      chk($sformatf("v%0d_mem_a0", v), 32'(rd), 32'(tbl[v].v0));
      mrd(tbl[v].a1, rd);
      chk($sformatf("v%0d_mem_a1", v), 32'(rd), 32'(tbl[v].v1));
    end

    // second start during a copy of 8 is ignored (memory is all 0x5A here)
    for (int i = 0; i < 8; i++) mwr(8'(8'h80 + i), 8'(8'h80 + i));
    run(1'b0, 8'h80, 8'hC0, 9'd8, 8'h00, 3, 0, 40);
    chk("ign_done_cycle", 32'(r_done_cyc), 17);
    chk("ign_done_pulses", 32'(r_ndone), 1);
    chk("ign_writes", 32'(r_nwr), 8);
    mrd(8'hC0, rd); chk("ign_mem_C0", 32'(rd), 32'h80);
    mrd(8'hC7, rd); chk("ign_mem_C7", 32'(rd), 32'h87);
    mrd(8'h00, rd); chk("ign_mem_00", 32'(rd), 32'h5A);
    mrd(8'h01, rd); chk("ign_mem_01", 32'(rd), 32'h5A);

    // reset during cycle 3 of a fill of 6
    for (int i = 20; i < 26; i++) mwr(8'(i), 8'h00);
    run(1'b1, 8'h00, 8'd20, 9'd6, 8'h3C, 0, 3, 10);
    chk("rst_mid_done_pulses", 32'(r_ndone), 0);
    chk("rst_mid_writes", 32'(r_nwr), 3);
    chk("rst_mid_wr_en_mask", 32'(r_mask), 32'h000E);
    chk("rst_mid_outputs_zero", 32'(r_postrst), 1);
    for (int i = 20; i < 26; i++) begin
      mrd(8'(i), rd);
      chk($sformatf("rst_mid_mem_%0d", i), 32'(rd), (i < 23) ? 32'h3C : 32'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
